// File: rtl/dbg_probe_capture_if.sv
// dbg_probe_capture_if: probe/LED debug bus; DBG_VALUE_TRIG_EN adds trig_value
interface dbg_probe_capture_if #(parameter int NCH = 64);
  logic [15:0] sw;
  logic [NCH*16-1:0] probe_bus;
  logic arm;
  logic trig_in;
`ifdef DBG_VALUE_TRIG_EN
  logic [15:0] trig_value;
`endif
  logic [15:0] led_data;
  logic [1:0] cap_state;
  logic trig_seen;
  modport master (
    output sw, probe_bus, arm, trig_in,
`ifdef DBG_VALUE_TRIG_EN
    output trig_value,
`endif
    input led_data, cap_state, trig_seen
  );
  modport slave (
    input sw, probe_bus, arm, trig_in,
`ifdef DBG_VALUE_TRIG_EN
    input trig_value,
`endif
    output led_data, cap_state, trig_seen
  );
endinterface

// File: rtl/dbg_probe_capture.sv
// dbg_probe_capture: LED probe mux with triggered trace buffer; DBG_VALUE_TRIG_EN adds value trigger
module dbg_probe_capture #(
  parameter int NCH = 64,
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int POST = 7
) (
  input logic clk,
  input logic rst,
  dbg_probe_capture_if.slave bus
);
  localparam int PRE = DEPTH - 1 - POST;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PRE = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, post_cnt_q, post_cnt_d;
  logic [AW:0] fill_q, fill_d;
  logic [7:0] cap_ch_q, cap_ch_d;
  logic [15:0] led_q, led_d;
  logic trig_seen_q, trig_seen_d;
  logic [15:0] mem [DEPTH];
  logic [7:0] ch;
  logic [AW-1:0] idx, rd_addr;
  logic [15:0] live, sample, trace;
  logic ch_ok, cap_ok, trig, trig_fire, wr_en;
  assign ch = bus.sw[15:8];
  assign idx = bus.sw[AW-1:0];
  assign ch_ok = {1'b0, ch} < 9'(NCH);
  assign cap_ok = {1'b0, cap_ch_q} < 9'(NCH);
  assign live = ch_ok ? bus.probe_bus[16*int'(ch) +: 16] : '0;
  assign sample = cap_ok ? bus.probe_bus[16*int'(cap_ch_q) +: 16] : '0;
`ifdef DBG_VALUE_TRIG_EN
  assign trig = bus.trig_in | (sample == bus.trig_value);
`else
  assign trig = bus.trig_in;
`endif
  assign trig_fire = !bus.arm && state_q == S_PRE && trig;
  assign wr_en = !bus.arm && (state_q == S_PRE || state_q == S_POST);
  // state register and capture bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      trig_ptr_q <= '0;
      post_cnt_q <= '0;
      fill_q <= '0;
      cap_ch_q <= '0;
      led_q <= '0;
      trig_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      post_cnt_q <= post_cnt_d;
      fill_q <= fill_d;
      cap_ch_q <= cap_ch_d;
      led_q <= led_d;
      trig_seen_q <= trig_seen_d;
    end
  end
  // trace memory, never reset; fill tracks which entries are valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample;
  end
  // next state: arm always restarts and beats a same-cycle trigger
  always_comb begin
    state_d = state_q;
    if (bus.arm) state_d = S_PRE;
    else if (trig_fire) state_d = (POST == 0) ? S_DONE : S_POST;
    else if (state_q == S_POST && post_cnt_q == AW'(1)) state_d = S_DONE;
  end
  // capture datapath and LED selection
  always_comb begin
    cap_ch_d = bus.arm ? ch : cap_ch_q;
    wr_ptr_d = bus.arm ? '0 : wr_ptr_q + AW'(wr_en);
    fill_d = bus.arm ? '0 : (wr_en && fill_q != (AW+1)'(DEPTH)) ? fill_q + (AW+1)'(1) : fill_q;
    trig_seen_d = bus.arm ? 1'b0 : (trig_seen_q | trig_fire);
    trig_ptr_d = trig_fire ? wr_ptr_q : trig_ptr_q;
    post_cnt_d = trig_fire ? AW'(POST) : (wr_en && state_q == S_POST) ? post_cnt_q - AW'(1) : post_cnt_q;
    rd_addr = trig_ptr_q - AW'(PRE) + idx;
    trace = (state_q == S_DONE && {1'b0, idx} >= (AW+1)'(DEPTH) - fill_q) ? mem[rd_addr] : '0;
    led_d = (bus.sw[7:6] == 2'b10) ? {state_q, trig_seen_q, 5'b0, cap_ch_q} :
            !ch_ok ? bus.sw :
            (bus.sw[7:6] == 2'b11) ? led_q :
            (bus.sw[7:6] == 2'b01) ? trace : live;
  end
  assign bus.led_data = led_q;
  assign bus.cap_state = state_q;
  assign bus.trig_seen = trig_seen_q;
endmodule

// File: tb/tb_dbg_probe_capture.sv
// tb_dbg_probe_capture: directed tests for probe mux, trace capture, freeze/status, restart
module tb_dbg_probe_capture;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  dbg_probe_capture_if #(.NCH(64)) pif();
  dbg_probe_capture #(.NCH(64), .DEPTH(16), .AW(4), .POST(7)) dut (.clk(clk), .rst(rst), .bus(pif.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    pif.probe_bus[16*k +: 16] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pif.sw = '0;
    pif.probe_bus = '0;
    pif.arm = 1'b0;
    pif.trig_in = 1'b0;
`ifdef DBG_VALUE_TRIG_EN
    pif.trig_value = 16'hFFFF;
`endif
    tick();
    tick();
    checks++; if (pif.led_data !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", pif.led_data); end
    checks++; if (pif.cap_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", pif.cap_state); end
    checks++; if (pif.trig_seen !== 1'b0) begin errors++; $display("FAIL reset_trig got %b exp 0", pif.trig_seen); end
    rst = 1'b0;
  endtask

  task automatic test_live();
    set_ch(5, 16'h1234);
    pif.sw = 16'h0500;
    tick();
    checks++; if (pif.led_data !== 16'h1234) begin errors++; $display("FAIL live_ch5 got %h exp 1234", pif.led_data); end
    pif.sw = 16'h4000;
    tick();
    checks++; if (pif.led_data !== 16'h4000) begin errors++; $display("FAIL live_invalid got %h exp 4000", pif.led_data); end
  endtask

  task automatic test_basic_capture();
    logic [15:0] idx_s [3] = '{16'h0348, 16'h0340, 16'h034F};
    logic [15:0] exp_s [3] = '{16'h0030, 16'h0028, 16'h0037};
    pif.sw = 16'h0300;
    set_ch(3, 16'h0020);
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    checks++; if (pif.cap_state !== 2'b01) begin errors++; $display("FAIL basic_pre got %b exp 01", pif.cap_state); end
    for (int v = 16'h20; v < 16'h30; v++) begin
      set_ch(3, 16'(v));
      tick();
    end
    set_ch(3, 16'h0030);
    pif.trig_in = 1'b1;
    tick();
    pif.trig_in = 1'b0;
    checks++; if (pif.cap_state !== 2'b10) begin errors++; $display("FAIL basic_post got %b exp 10", pif.cap_state); end
    checks++; if (pif.trig_seen !== 1'b1) begin errors++; $display("FAIL basic_trig_seen got %b exp 1", pif.trig_seen); end
    for (int v = 16'h31; v <= 16'h37; v++) begin
      set_ch(3, 16'(v));
      tick();
      if (v == 16'h36) begin
        checks++; if (pif.cap_state !== 2'b10) begin errors++; $display("FAIL basic_post6 got %b exp 10", pif.cap_state); end
      end
    end
    checks++; if (pif.cap_state !== 2'b11) begin errors++; $display("FAIL basic_done got %b exp 11", pif.cap_state); end
    set_ch(3, 16'h0099);
    tick();
    tick();
    pif.sw = 16'h0308;
    tick();
    checks++; if (pif.led_data !== 16'h0099) begin errors++; $display("FAIL basic_live got %h exp 0099", pif.led_data); end
    for (int i = 0; i < 3; i++) begin
      pif.sw = idx_s[i];
      tick();
      checks++; if (pif.led_data !== exp_s[i]) begin errors++; $display("FAIL basic_trace sw=%h got %h exp %h", idx_s[i], pif.led_data, exp_s[i]); end
    end
  endtask

  task automatic test_early_trigger();
    logic [3:0] idx_s [7] = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    logic [15:0] exp_s [7] = '{16'h0000, 16'h0000, 16'h0050, 16'h0051, 16'h0052, 16'h0053, 16'h0059};
    pif.sw = 16'h0300;
    set_ch(3, 16'h0050);
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    tick();
    set_ch(3, 16'h0051);
    tick();
    set_ch(3, 16'h0052);
    pif.trig_in = 1'b1;
    tick();
    pif.trig_in = 1'b0;
    for (int v = 16'h53; v <= 16'h59; v++) begin
      set_ch(3, 16'(v));
      tick();
    end
    checks++; if (pif.cap_state !== 2'b11) begin errors++; $display("FAIL early_done got %b exp 11", pif.cap_state); end
    for (int i = 0; i < 7; i++) begin
      pif.sw = {12'h034, idx_s[i]};
      tick();
      checks++; if (pif.led_data !== exp_s[i]) begin errors++; $display("FAIL early_trace i=%0d got %h exp %h", idx_s[i], pif.led_data, exp_s[i]); end
    end
  endtask

  task automatic test_freeze_status();
    set_ch(7, 16'hAAAA);
    pif.sw = 16'h0700;
    tick();
    checks++; if (pif.led_data !== 16'hAAAA) begin errors++; $display("FAIL freeze_live got %h exp aaaa", pif.led_data); end
    pif.sw = 16'h07C0;
    tick();
    set_ch(7, 16'h5555);
    tick();
    checks++; if (pif.led_data !== 16'hAAAA) begin errors++; $display("FAIL freeze_hold got %h exp aaaa", pif.led_data); end
    pif.sw = 16'h0780;
    tick();
    checks++; if (pif.led_data !== 16'hE003) begin errors++; $display("FAIL status_done got %h exp e003", pif.led_data); end
    pif.sw = 16'h4080;
    tick();
    checks++; if (pif.led_data !== 16'hE003) begin errors++; $display("FAIL status_invalid_ch got %h exp e003", pif.led_data); end
  endtask

  task automatic test_restart_reset();
    pif.sw = 16'h0340;
    set_ch(3, 16'h0001);
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    tick();
    pif.trig_in = 1'b1;
    tick();
    pif.trig_in = 1'b0;
    tick();
    checks++; if (pif.cap_state !== 2'b10 || pif.trig_seen !== 1'b1) begin errors++; $display("FAIL restart_in_post got %b/%b exp 10/1", pif.cap_state, pif.trig_seen); end
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    checks++; if (pif.cap_state !== 2'b01 || pif.trig_seen !== 1'b0) begin errors++; $display("FAIL restart_state got %b/%b exp 01/0", pif.cap_state, pif.trig_seen); end
    tick();
    checks++; if (pif.led_data !== 16'h0) begin errors++; $display("FAIL restart_trace got %h exp 0000", pif.led_data); end
    pif.arm = 1'b1;
    pif.trig_in = 1'b1;
    tick();
    pif.arm = 1'b0;
    checks++; if (pif.cap_state !== 2'b01 || pif.trig_seen !== 1'b0) begin errors++; $display("FAIL arm_priority got %b/%b exp 01/0", pif.cap_state, pif.trig_seen); end
    tick();
    tick();
    pif.trig_in = 1'b0;
    checks++; if (pif.cap_state !== 2'b10) begin errors++; $display("FAIL held_trig got %b exp 10", pif.cap_state); end
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    pif.sw = 16'h0300;
    set_ch(3, 16'h0077);
    tick();
    checks++; if (pif.led_data !== 16'h0077) begin errors++; $display("FAIL pre_live got %h exp 0077", pif.led_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pif.led_data !== 16'h0 || pif.cap_state !== 2'b00 || pif.trig_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_pre got %h/%b/%b exp 0000/00/0", pif.led_data, pif.cap_state, pif.trig_seen); end
  endtask

  task automatic test_value_trig();
`ifdef DBG_VALUE_TRIG_EN
    pif.trig_value = 16'h0042;
`endif
    pif.sw = 16'h0300;
    set_ch(3, 16'h0040);
    pif.arm = 1'b1;
    tick();
    pif.arm = 1'b0;
    tick();
    set_ch(3, 16'h0041);
    tick();
    checks++; if (pif.cap_state !== 2'b01) begin errors++; $display("FAIL vtrig_pre got %b exp 01", pif.cap_state); end
    set_ch(3, 16'h0042);
    tick();
    set_ch(3, 16'h0043);
`ifdef DBG_VALUE_TRIG_EN
    checks++; if (pif.cap_state !== 2'b10 || pif.trig_seen !== 1'b1) begin errors++; $display("FAIL vtrig_hit got %b/%b exp 10/1", pif.cap_state, pif.trig_seen); end
`else
    checks++; if (pif.cap_state !== 2'b01 || pif.trig_seen !== 1'b0) begin errors++; $display("FAIL vtrig_none got %b/%b exp 01/0", pif.cap_state, pif.trig_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_live();
    test_basic_capture();
    test_early_trigger();
    test_freeze_status();
    test_restart_reset();
    test_value_trig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
